// File: rtl/matrix_mem_responder_pkg.sv
// Shared definitions for the matrix memory responder.
// Contents: element/dimension constants, operand row (row_t) and result row
// (crow_t) types, and the responder FSM state encoding.
package mm_pkg;
  localparam int DW = 32;            // element width
  localparam int N  = 32;            // operand matrix dimension
  localparam int CN = 33;            // result dimension incl. checksum row/column
  localparam int AW = 6;             // row address width, clog2(CN)
  localparam int PW = $clog2(N);     // operand row pointer width

  typedef logic [N*DW-1:0]  row_t;
  typedef logic [CN*DW-1:0] crow_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;
endpackage

// File: rtl/matrix_mem_responder_if.sv
// Accelerator-side fetch/store bus of the matrix memory responder.
// Handshake: fetch_A/fetch_B are level requests, one operand row is returned on
// data_in the cycle after each sampled request. store_C is a level "row valid"
// on dataCf_out; the responder captures it once and answers with a one-cycle
// store_C_ready, and does not sample store_C again until store_C_ready drops.
// start is a one-cycle kick to the accelerator, finish reports run completion.
// Modports: slave = responder (this block), master = accelerator.
interface matrix_mem_responder_if;
  import mm_pkg::*;

  logic  fetch_A;
  logic  fetch_B;
  logic  store_C;
  crow_t dataCf_out;
  logic  finish;
  row_t  data_in;
  logic  start;
  logic  store_C_ready;

  modport slave (
    input  fetch_A, fetch_B, store_C, dataCf_out, finish,
    output data_in, start, store_C_ready
  );

  modport master (
    output fetch_A, fetch_B, store_C, dataCf_out, finish,
    input  data_in, start, store_C_ready
  );
endinterface

// File: rtl/matrix_mem_responder_row_ram.sv
// mm_row_ram: row-wide RAM, one write port, one registered read port.
// Ports: we/waddr/wdata write (addresses >= DEPTH are dropped);
//        re/raddr/rdata read, rdata updates only when re=1 and returns 0
//        for addresses >= DEPTH. rdata resets to 0; the array does not.
module mm_row_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 1024,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_ok;
  logic rd_ok;
  assign wr_ok = ({1'b0, waddr} < DEPTH_W);
  assign rd_ok = ({1'b0, raddr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (we && wr_ok) mem[waddr[IW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_ok ? mem[raddr[IW-1:0]] : '0;
    end
  end
endmodule

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder: memory-side responder for the checksum matrix-multiply
// accelerator. Holds host-written operand matrices A and B, streams their rows
// on fetch requests, captures result rows on store_C, and tracks run status.
// Ports: clk, rst_n (async, active low); host_* operand write and C read port;
//        busy/done/c_overflow status; dbg_state FSM state; acc = accelerator bus.
module matrix_mem_responder
  import mm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_go,
  input  logic          host_wr_en,
  input  logic          host_wr_sel,
  input  logic [AW-1:0] host_wr_addr,
  input  row_t          host_wr_data,
  input  logic [AW-1:0] host_rd_addr,
  output crow_t         host_rd_data,
  output logic          busy,
  output logic          done,
  output logic          c_overflow,
  output state_t        dbg_state,
  matrix_mem_responder_if.slave acc
);
  state_t        state_q, state_d;
  logic [PW-1:0] a_ptr, b_ptr;
  logic [AW-1:0] c_ptr;
  logic          sel_b;            // which operand RAM last drove data_in
  logic          start_q, ready_q;
  row_t          a_rdata, b_rdata;

  logic go, serve_a, serve_b, cap, c_we, ovf_set, fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // store_C wins over fetch; finish is honoured after any same-cycle capture.
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    serve_a = 1'b0;
    serve_b = 1'b0;
    cap     = 1'b0;
    c_we    = 1'b0;
    ovf_set = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_go) begin
          go      = 1'b1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (acc.store_C) begin
          cap     = 1'b1;
          c_we    = (c_ptr < AW'(CN));
          ovf_set = !(c_ptr < AW'(CN));
          state_d = ACK;
        end else if (acc.fetch_A) begin
          serve_a = 1'b1;
        end else if (acc.fetch_B) begin
          serve_b = 1'b1;
        end
        if (acc.finish) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = SERVE;
        if (acc.finish) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ptr      <= '0;
      b_ptr      <= '0;
      c_ptr      <= '0;
      sel_b      <= 1'b0;
      start_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      c_overflow <= 1'b0;
    end else begin
      start_q <= go;
      ready_q <= cap;
      if (go) begin
        busy       <= 1'b1;
        c_ptr      <= '0;
        done       <= 1'b0;
        c_overflow <= 1'b0;
      end
      if (fin) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (c_we)    c_ptr <= c_ptr + 1'b1;
      if (ovf_set) c_overflow <= 1'b1;
      // Pointers are log2(N) wide, so they wrap N-1 -> 0 naturally.
      if (serve_a) begin
        a_ptr <= a_ptr + 1'b1;
        sel_b <= 1'b0;
      end
      if (serve_b) begin
        b_ptr <= b_ptr + 1'b1;
        sel_b <= 1'b1;
      end
    end
  end

  // Operand RAM read registers only advance on a serve, so data_in holds
  // its last row while fetch is low.
  mm_row_ram #(.DEPTH(N), .WIDTH(N*DW), .AW(AW)) u_a_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (host_wr_en && !busy && !host_wr_sel),
    .waddr (host_wr_addr),
    .wdata (host_wr_data),
    .re    (serve_a),
    .raddr ({1'b0, a_ptr}),
    .rdata (a_rdata)
  );

  mm_row_ram #(.DEPTH(N), .WIDTH(N*DW), .AW(AW)) u_b_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (host_wr_en && !busy && host_wr_sel),
    .waddr (host_wr_addr),
    .wdata (host_wr_data),
    .re    (serve_b),
    .raddr ({1'b0, b_ptr}),
    .rdata (b_rdata)
  );

  mm_row_ram #(.DEPTH(CN), .WIDTH(CN*DW), .AW(AW)) u_c_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (c_we),
    .waddr (c_ptr),
    .wdata (acc.dataCf_out),
    .re    (1'b1),
    .raddr (host_rd_addr),
    .rdata (host_rd_data)
  );

  assign acc.data_in       = sel_b ? b_rdata : a_rdata;
  assign acc.start         = start_q;
  assign acc.store_C_ready = ready_q;
  assign dbg_state         = state_q;
endmodule
